// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_mem_pkg;

  localparam int unsigned MEM_BYTES_DEF = 256;
  localparam int unsigned INSTR_W       = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } loader_state_e;

  typedef logic [1:0] lane_idx_t;

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    popcount4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into a 32-bit word with a pending-lane mask.
module byte_packer
  import instr_mem_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic [7:0]         byte_i,
  output lane_idx_t          lane_o,
  output logic [3:0]         mask_o,
  output logic [3:0]         mask_next_o,
  output logic [INSTR_W-1:0] word_next_o
);

  lane_idx_t          lane_q, lane_d;
  logic [3:0]         mask_q, mask_d;
  logic [INSTR_W-1:0] word_q, word_d;

  // Next values reflect a push only; clear is applied at the register so the
  // top can sample the completed word on the same cycle the last lane fills.
  always_comb begin
    lane_d = lane_q;
    mask_d = mask_q;
    word_d = word_q;
    if (push_i) begin
      word_d[{lane_q, 3'b000} +: 8] = byte_i;
      mask_d[lane_q]                = 1'b1;
      lane_d                        = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      lane_q <= '0;
      mask_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      mask_q <= mask_d;
      word_q <= word_d;
    end
  end

  assign lane_o      = lane_q;
  assign mask_o      = mask_q;
  assign mask_next_o = mask_d;
  assign word_next_o = word_d;

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a program image into the instruction store and stalls the CPU until done.
// Define LOADER_CHECKSUM_EN to treat the final byte as an 8-bit checksum trailer.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  input  logic               byte_last,
  output logic               byte_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic [3:0]         wr_be,
  output logic               cpu_stall,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    load_bytes
);

  localparam int unsigned CntW = ADDR_W + 1;

  loader_state_e      state_q;
  logic               byte_ready_q, wr_en_q, cpu_stall_q, done_q, error_q, last_seen_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [INSTR_W-1:0] wr_data_q;
  logic [3:0]         wr_be_q;
  logic [CntW-1:0]    load_bytes_q;

  lane_idx_t          pk_lane;
  logic [3:0]         pk_mask, pk_mask_next;
  logic [INSTR_W-1:0] pk_word_next;
  logic               pk_clear, pk_push;

  logic               accept, start_ok, is_data, at_capacity, drop, word_full, trailer_bad;
  logic [CntW:0]      occupied;
  logic [CntW-1:0]    load_next;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       chk_bad_q;
`endif

  always_comb begin
    accept   = byte_valid & byte_ready_q;
    start_ok = start & ((state_q == StIdle) | (state_q == StDone));
`ifdef LOADER_CHECKSUM_EN
    is_data     = ~byte_last;
    trailer_bad = (sum_q + byte_in) != 8'h00;
`else
    is_data     = 1'b1;
    trailer_bad = 1'b0;
`endif
    // Capacity counts bytes already written plus bytes waiting in the packer.
    occupied    = (CntW + 1)'(load_bytes_q) + (CntW + 1)'(popcount4(pk_mask));
    at_capacity = occupied >= (CntW + 1)'(MEM_BYTES);
    pk_push     = accept & is_data & ~at_capacity;
    drop        = accept & is_data & at_capacity;
    pk_clear    = start_ok | (state_q == StWrite);
    word_full   = pk_push & (pk_lane == 2'd3);
    load_next   = load_bytes_q + CntW'(popcount4(wr_be_q));
  end

  byte_packer u_packer (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (pk_clear),
    .push_i      (pk_push),
    .byte_i      (byte_in),
    .lane_o      (pk_lane),
    .mask_o      (pk_mask),
    .mask_next_o (pk_mask_next),
    .word_next_o (pk_word_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
      cpu_stall_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      load_bytes_q <= '0;
      last_seen_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
      chk_bad_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_ok) begin
            state_q      <= StRecv;
            byte_ready_q <= 1'b1;
            done_q       <= 1'b0;
            cpu_stall_q  <= 1'b1;
            error_q      <= 1'b0;
            wr_addr_q    <= '0;
            load_bytes_q <= '0;
            last_seen_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
            chk_bad_q    <= 1'b0;
`endif
          end
        end
        StRecv: begin
          if (accept) begin
            if (drop) error_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            if (is_data) sum_q <= sum_q + byte_in;
`endif
            if (word_full || (byte_last && pk_mask_next != 4'h0)) begin
              state_q      <= StWrite;
              byte_ready_q <= 1'b0;
              wr_en_q      <= 1'b1;
              wr_data_q    <= pk_word_next;
              wr_be_q      <= pk_mask_next;
              last_seen_q  <= byte_last;
`ifdef LOADER_CHECKSUM_EN
              chk_bad_q    <= byte_last & trailer_bad;
`endif
            end else if (byte_last) begin
              state_q      <= StDone;
              byte_ready_q <= 1'b0;
              done_q       <= 1'b1;
              cpu_stall_q  <= 1'b0;
              if (trailer_bad) error_q <= 1'b1;
            end
          end
        end
        StWrite: begin
          wr_en_q      <= 1'b0;
          wr_data_q    <= '0;
          wr_be_q      <= '0;
          load_bytes_q <= load_next;
          // Hold the address at the top of the store rather than wrapping to 0.
          if (load_next < CntW'(MEM_BYTES)) wr_addr_q <= wr_addr_q + ADDR_W'(4);
          if (last_seen_q) begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            cpu_stall_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            if (chk_bad_q) error_q <= 1'b1;
`endif
          end else begin
            state_q      <= StRecv;
            byte_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_be      = wr_be_q;
  assign cpu_stall  = cpu_stall_q;
  assign done       = done_q;
  assign error      = error_q;
  assign load_bytes = load_bytes_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes queued by stimulus, checked by a monitor.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid, byte_last;
  logic [7:0]  byte_in;
  logic        byte_ready, wr_en, cpu_stall, done, error;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [8:0]  load_bytes;

  int n_vec = 0;
  int n_bad = 0;
  int n_accepted = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  instr_mem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_be      (wr_be),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .error      (error),
    .load_bytes (load_bytes)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h be %0h, expected no write",
                 wr_addr, wr_data, wr_be);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check("wr_data", wr_data, mon_e.data);
        check("wr_be", 32'(wr_be), 32'(mon_e.be));
        check("ready_during_write", 32'(byte_ready), 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.be   = be;
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    logic ok;
    ok         = 1'b0;
    byte_in    = b;
    byte_last  = last;
    byte_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL handshake: byte %0h not accepted, expected accept within 40 cycles", b);
    end else begin
      n_accepted++;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check(name, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic end_checks(input string tag, input int lb, input logic err);
    @(negedge clk);
    check({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
    check({tag, "_load_bytes"}, 32'(load_bytes), 32'(lb));
    check({tag, "_error"}, 32'(error), 32'(err));
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [7:0] prog [8];
    logic [7:0] five [5];
    logic [31:0] w;
    prog = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    five = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; byte_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_wr_be", 32'(wr_be), 32'd0);
    check("rst_cpu_stall", 32'(cpu_stall), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_load_bytes", 32'(load_bytes), 32'd0);
    @(posedge clk);
    #1;

`ifdef LOADER_CHECKSUM_EN
    // 01+02+03+04 = 0A, trailer F6 brings the sum to 0 mod 256.
    do_start();
    push_exp(8'h00, 32'h04030201, 4'hF);
    send_byte(8'h01, 1'b0, 0);
    send_byte(8'h02, 1'b0, 0);
    send_byte(8'h03, 1'b0, 0);
    send_byte(8'h04, 1'b0, 0);
    send_byte(8'hF6, 1'b1, 0);
    wait_done("chk_good_done");
    end_checks("chk_good", 4, 1'b0);

    do_start();
    push_exp(8'h00, 32'h04030201, 4'hF);
    send_byte(8'h01, 1'b0, 0);
    send_byte(8'h02, 1'b0, 0);
    send_byte(8'h03, 1'b0, 0);
    send_byte(8'h04, 1'b0, 0);
    send_byte(8'hF7, 1'b1, 0);
    wait_done("chk_bad_done");
    end_checks("chk_bad", 4, 1'b1);
`else
    // Two full words at full rate.
    do_start();
    @(negedge clk);
    check("recv_byte_ready", 32'(byte_ready), 32'd1);
    check("recv_cpu_stall", 32'(cpu_stall), 32'd1);
    @(posedge clk);
    #1;
    push_exp(8'h00, 32'h00100013, 4'hF);
    push_exp(8'h04, 32'h00200093, 4'hF);
    for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7, 0);
    wait_done("t1_done");
    end_checks("t1", 8, 1'b0);

    // Partial trailing word.
    do_start();
    push_exp(8'h00, 32'hDDCCBBAA, 4'hF);
    push_exp(8'h04, 32'h000000EE, 4'h1);
    for (int i = 0; i < 5; i++) send_byte(five[i], i == 4, 0);
    wait_done("t2_done");
    end_checks("t2", 5, 1'b0);

    // Same program with random valid gaps.
    do_start();
    push_exp(8'h00, 32'h00100013, 4'hF);
    push_exp(8'h04, 32'h00200093, 4'hF);
    for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7, int'($urandom_range(0, 1)));
    wait_done("t3_done");
    end_checks("t3", 8, 1'b0);

    // Overflow: 260 bytes into a 256-byte store.
    do_start();
    n_accepted = 0;
    for (int wi = 0; wi < 64; wi++) begin
      w = {8'(4 * wi + 3), 8'(4 * wi + 2), 8'(4 * wi + 1), 8'(4 * wi)};
      push_exp(8'(4 * wi), w, 4'hF);
    end
    for (int i = 0; i < 260; i++) send_byte(8'(i), i == 259, 0);
    check("t4_accepted", 32'(n_accepted), 32'd260);
    wait_done("t4_done");
    end_checks("t4", 256, 1'b1);

    // Reset mid-word discards the partial word.
    do_start();
    send_byte(8'h55, 1'b0, 0);
    send_byte(8'h66, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_rst_ready", 32'(byte_ready), 32'd0);
    check("t5_rst_stall", 32'(cpu_stall), 32'd1);
    check("t5_rst_load", 32'(load_bytes), 32'd0);
    @(posedge clk);
    #1;
    do_start();
    push_exp(8'h00, 32'h44332211, 4'hF);
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h33, 1'b0, 0);
    send_byte(8'h44, 1'b1, 0);
    wait_done("t5_done");
    end_checks("t5", 4, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
